// File: rtl/jelly_vsync_adjust_de_pkg.sv
// Shared constants for the vsync-adjust DE sequencer: register map, control bits, states.
package jelly_vsync_adjust_de_pkg;

    localparam logic [7:0] ADR_CTL    = 8'h04;
    localparam logic [7:0] ADR_HSIZE  = 8'h08;
    localparam logic [7:0] ADR_VSIZE  = 8'h09;
    localparam logic [7:0] ADR_HSTART = 8'h0a;
    localparam logic [7:0] ADR_VSTART = 8'h0b;

    localparam int CTL_BIT_ENABLE = 0;
    localparam int CTL_BIT_UPDATE = 1;

    localparam int TIMER_WIDTH = 16;

    typedef enum logic [3:0] {
        IDLE,
        WR_HSIZE,
        WR_VSIZE,
        WR_HSTART,
        WR_VSTART,
        WR_CTL,
        UPD,
        POLL,
        POLL_GAP,
        DONE
    } state_t;

    function automatic logic [7:0] state_adr(input state_t st);
        case (st)
            WR_HSIZE:        return ADR_HSIZE;
            WR_VSIZE:        return ADR_VSIZE;
            WR_HSTART:       return ADR_HSTART;
            WR_VSTART:       return ADR_VSTART;
            WR_CTL, POLL:    return ADR_CTL;
            default:         return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/jelly_vsync_adjust_de_seq_timer.sv
// Saturating poll timer: cleared while the sequencer issues the update, counts while polling.
module jelly_vsync_adjust_de_seq_timer
    import jelly_vsync_adjust_de_pkg::*;
    (
        input  logic reset,
        input  logic clk,
        input  logic clear,
        input  logic run,
        output logic expired
    );

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = &count;

endmodule

// File: rtl/jelly_vsync_adjust_de_sequencer.sv
// Programs the vsync-adjust DE block over Wishbone, triggers an update and polls until it lands.
// Optional poll timeout: define JELLY_VSYNC_ADJUST_DE_SEQUENCER_TIMEOUT_EN.
module jelly_vsync_adjust_de_sequencer
    import jelly_vsync_adjust_de_pkg::*;
    #(
        parameter int WB_ADR_WIDTH  = 8,
        parameter int WB_DAT_WIDTH  = 32,
        parameter int H_COUNT_WIDTH = 14,
        parameter int V_COUNT_WIDTH = 14
    )
    (
        input  logic                       reset,
        input  logic                       clk,

        input  logic                       s_enable,
        input  logic [H_COUNT_WIDTH-1:0]   s_hsize,
        input  logic [V_COUNT_WIDTH-1:0]   s_vsize,
        input  logic [H_COUNT_WIDTH-1:0]   s_hstart,
        input  logic [V_COUNT_WIDTH-1:0]   s_vstart,
        input  logic                       s_valid,
        output logic                       s_ready,

        output logic [WB_ADR_WIDTH-1:0]    m_wb_adr_o,
        input  logic [WB_DAT_WIDTH-1:0]    m_wb_dat_i,
        output logic [WB_DAT_WIDTH-1:0]    m_wb_dat_o,
        output logic                       m_wb_we_o,
        output logic [WB_DAT_WIDTH/8-1:0]  m_wb_sel_o,
        output logic                       m_wb_stb_o,
        input  logic                       m_wb_ack_i,

        output logic                       out_update_req,
        output logic                       out_done,
        output logic                       out_error
    );

    state_t                     state;
    state_t                     state_next;
    logic                       timeout_hit;
    logic                       expired;

    logic                       enable_q;
    logic [H_COUNT_WIDTH-1:0]   hsize_q;
    logic [V_COUNT_WIDTH-1:0]   vsize_q;
    logic [H_COUNT_WIDTH-1:0]   hstart_q;
    logic [V_COUNT_WIDTH-1:0]   vstart_q;

    logic                       p_enable;
    logic [H_COUNT_WIDTH-1:0]   p_hsize;
    logic [V_COUNT_WIDTH-1:0]   p_vsize;
    logic [H_COUNT_WIDTH-1:0]   p_hstart;
    logic [V_COUNT_WIDTH-1:0]   p_vstart;
    logic [1:0]                 ctl_word;
    logic [WB_DAT_WIDTH-1:0]    dat_next;
    logic                       unused_dat;

    assign unused_dat = ^m_wb_dat_i;
    assign m_wb_sel_o = '1;

`ifdef JELLY_VSYNC_ADJUST_DE_SEQUENCER_TIMEOUT_EN
    jelly_vsync_adjust_de_seq_timer u_timer (
        .reset   (reset),
        .clk     (clk),
        .clear   (state == UPD),
        .run     (state == POLL || state == POLL_GAP),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (s_valid)    state_next = WR_HSIZE;
            WR_HSIZE:  if (m_wb_ack_i) state_next = WR_VSIZE;
            WR_VSIZE:  if (m_wb_ack_i) state_next = WR_HSTART;
            WR_HSTART: if (m_wb_ack_i) state_next = WR_VSTART;
            WR_VSTART: if (m_wb_ack_i) state_next = WR_CTL;
            WR_CTL:    if (m_wb_ack_i) state_next = UPD;
            UPD:                       state_next = POLL;
            POLL: begin
                // an access in flight is always allowed to finish before the timeout is honoured
                if (m_wb_ack_i) begin
                    if (!m_wb_dat_i[CTL_BIT_UPDATE]) begin
                        state_next = DONE;
                    end else if (expired) begin
                        state_next  = DONE;
                        timeout_hit = 1'b1;
                    end else begin
                        state_next = POLL_GAP;
                    end
                end
            end
            POLL_GAP: begin
                state_next  = expired ? DONE : POLL;
                timeout_hit = expired;
            end
            DONE:                      state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // outputs are registered from state_next, so parameters latched this edge are taken from the inputs
    assign p_enable = (state == IDLE) ? s_enable : enable_q;
    assign p_hsize  = (state == IDLE) ? s_hsize  : hsize_q;
    assign p_vsize  = (state == IDLE) ? s_vsize  : vsize_q;
    assign p_hstart = (state == IDLE) ? s_hstart : hstart_q;
    assign p_vstart = (state == IDLE) ? s_vstart : vstart_q;

    always_comb begin
        ctl_word                 = '0;
        ctl_word[CTL_BIT_UPDATE] = 1'b1;
        ctl_word[CTL_BIT_ENABLE] = p_enable;
        case (state_next)
            WR_HSIZE:  dat_next = WB_DAT_WIDTH'(p_hsize);
            WR_VSIZE:  dat_next = WB_DAT_WIDTH'(p_vsize);
            WR_HSTART: dat_next = WB_DAT_WIDTH'(p_hstart);
            WR_VSTART: dat_next = WB_DAT_WIDTH'(p_vstart);
            WR_CTL:    dat_next = WB_DAT_WIDTH'(ctl_word);
            default:   dat_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            enable_q       <= 1'b0;
            hsize_q        <= '0;
            vsize_q        <= '0;
            hstart_q       <= '0;
            vstart_q       <= '0;
            s_ready        <= 1'b1;
            m_wb_adr_o     <= '0;
            m_wb_dat_o     <= '0;
            m_wb_we_o      <= 1'b0;
            m_wb_stb_o     <= 1'b0;
            out_update_req <= 1'b0;
            out_done       <= 1'b0;
            out_error      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && s_valid) begin
                enable_q <= s_enable;
                hsize_q  <= s_hsize;
                vsize_q  <= s_vsize;
                hstart_q <= s_hstart;
                vstart_q <= s_vstart;
            end
            s_ready        <= (state_next == IDLE);
            m_wb_adr_o     <= WB_ADR_WIDTH'(state_adr(state_next));
            m_wb_dat_o     <= dat_next;
            m_wb_we_o      <= (state_next inside {WR_HSIZE, WR_VSIZE, WR_HSTART, WR_VSTART, WR_CTL});
            m_wb_stb_o     <= (state_next inside {WR_HSIZE, WR_VSIZE, WR_HSTART, WR_VSTART, WR_CTL, POLL});
            out_update_req <= (state_next == UPD);
            out_done       <= (state_next == DONE);
            out_error      <= (state_next == DONE) && timeout_hit;
        end
    end

endmodule

// File: tb/tb_jelly_vsync_adjust_de_sequencer.sv
// Randomized bench with a transaction-level scoreboard; timeout case runs when
// JELLY_VSYNC_ADJUST_DE_SEQUENCER_TIMEOUT_EN is defined.
module tb_jelly_vsync_adjust_de_sequencer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int HW = 14;
    localparam int VW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_enable = 1'b0;
    logic [HW-1:0] s_hsize = '0;
    logic [VW-1:0] s_vsize = '0;
    logic [HW-1:0] s_hstart = '0;
    logic [VW-1:0] s_vstart = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] m_wb_adr_o;
    logic [DW-1:0] m_wb_dat_i;
    logic [DW-1:0] m_wb_dat_o;
    logic          m_wb_we_o;
    logic [DW/8-1:0] m_wb_sel_o;
    logic          m_wb_stb_o;
    logic          m_wb_ack_i;
    logic          out_update_req;
    logic          out_done;
    logic          out_error;

    always #5 clk = ~clk;

    jelly_vsync_adjust_de_sequencer #(
        .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .H_COUNT_WIDTH(HW), .V_COUNT_WIDTH(VW)
    ) dut (
        .reset(reset), .clk(clk),
        .s_enable(s_enable), .s_hsize(s_hsize), .s_vsize(s_vsize),
        .s_hstart(s_hstart), .s_vstart(s_vstart), .s_valid(s_valid), .s_ready(s_ready),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_ack_i(m_wb_ack_i),
        .out_update_req(out_update_req), .out_done(out_done), .out_error(out_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- slave: random ack latency, busy-bit reply ----------------
    int unsigned dly_lo = 0;
    int unsigned dly_hi = 0;
    int          busy_target = 0;
    bit          busy_forever = 1'b0;
    logic [3:0]  wait_cnt;
    logic [3:0]  cur_delay;
    int          rd_count;

    assign m_wb_ack_i = m_wb_stb_o && (wait_cnt == cur_delay);
    assign m_wb_dat_i = (busy_forever || rd_count < busy_target) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            cur_delay <= '0;
            rd_count  <= 0;
        end else begin
            if (s_valid && s_ready) cur_delay <= 4'($urandom_range(dly_hi, dly_lo));
            if (m_wb_stb_o && !m_wb_ack_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
                if (m_wb_ack_i) cur_delay <= 4'($urandom_range(dly_hi, dly_lo));
            end
            if (s_valid && s_ready) rd_count <= 0;
            else if (m_wb_ack_i && !m_wb_we_o) rd_count <= rd_count + 1;
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [31:0] dat;
    } acc_t;

    acc_t exp_q[$];
    acc_t log_q[$];
    bit   to_mode = 1'b0;
    bit   busy = 1'b0;
    int   cyc = 0;
    int   hs_cyc, upd_cyc, done_cyc, last_wr_ack, last_rd_ack;
    int   wr_popped, rd_popped, n_upd, done_cnt = 0, wr_stb_cycles;
    logic prev_stb = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [AW-1:0] prev_adr;
    logic [DW-1:0] prev_dat;

    always @(negedge clk) begin
        acc_t e;
        cyc++;
        if (reset) begin
            exp_q.delete();
            busy     = 1'b0;
            prev_stb = 1'b0;
            prev_ack = 1'b0;
        end else begin
            chk("s_ready", s_ready, !busy);
            if (m_wb_stb_o) chk("sel all ones", m_wb_sel_o, 4'hF);
            if (!m_wb_we_o) chk("dat_o zero on read/idle", m_wb_dat_o, 0);
            if (!out_done)  chk("error without done", out_error, 0);
            if (prev_stb && !prev_ack) begin
                chk("stb held", m_wb_stb_o, 1);
                chk("adr held", m_wb_adr_o, prev_adr);
                chk("we held", m_wb_we_o, prev_we);
                chk("dat held", m_wb_dat_o, prev_dat);
            end else if (prev_stb && prev_ack && prev_we && wr_popped < 5) begin
                chk("write burst continuous", m_wb_stb_o, 1);
            end
            if (m_wb_stb_o && !prev_stb) begin
                if (m_wb_we_o)          chk("first write timing", cyc, hs_cyc + 1);
                else if (rd_popped == 0) chk("first poll timing", cyc, upd_cyc + 1);
                else if (!to_mode)      chk("poll gap", cyc, last_rd_ack + 2);
            end
            if (m_wb_stb_o && m_wb_we_o) wr_stb_cycles++;
            if (m_wb_stb_o && m_wb_ack_i) begin
                log_q.push_back('{adr: m_wb_adr_o, we: m_wb_we_o, dat: m_wb_dat_o});
                if (m_wb_we_o) begin wr_popped++; last_wr_ack = cyc; end
                else begin rd_popped++; last_rd_ack = cyc; end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("access adr", m_wb_adr_o, e.adr);
                    chk("access we", m_wb_we_o, e.we);
                    chk("access dat", m_wb_dat_o, e.dat);
                end else if (to_mode && !m_wb_we_o) begin
                    chk("timeout poll adr", m_wb_adr_o, 8'h04);
                end else begin
                    chk("unexpected access", 1, 0);
                end
            end
            if (out_update_req) begin
                n_upd++;
                upd_cyc = cyc;
                chk("update timing", cyc, last_wr_ack + 1);
                chk("writes before update", wr_popped, 5);
            end
            if (out_done) begin
                chk("done error flag", out_error, to_mode);
                chk("scoreboard drained", exp_q.size(), 0);
                if (!to_mode) chk("done timing", cyc, last_rd_ack + 1);
                busy     = 1'b0;
                done_cyc = cyc;
                done_cnt++;
            end
            if (s_valid && s_ready) begin
                busy          = 1'b1;
                hs_cyc        = cyc;
                wr_popped     = 0;
                rd_popped     = 0;
                n_upd         = 0;
                wr_stb_cycles = 0;
                log_q.delete();
                exp_q.push_back('{adr: 8'h08, we: 1'b1, dat: 32'(s_hsize)});
                exp_q.push_back('{adr: 8'h09, we: 1'b1, dat: 32'(s_vsize)});
                exp_q.push_back('{adr: 8'h0a, we: 1'b1, dat: 32'(s_hstart)});
                exp_q.push_back('{adr: 8'h0b, we: 1'b1, dat: 32'(s_vstart)});
                exp_q.push_back('{adr: 8'h04, we: 1'b1, dat: {30'd0, 1'b1, s_enable}});
                if (!to_mode)
                    for (int i = 0; i <= busy_target; i++)
                        exp_q.push_back('{adr: 8'h04, we: 1'b0, dat: 32'd0});
            end
            prev_stb = m_wb_stb_o;
            prev_ack = m_wb_ack_i;
            prev_we  = m_wb_we_o;
            prev_adr = m_wb_adr_o;
            prev_dat = m_wb_dat_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int h, input int v, input int hs, input int vs, input bit en);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        s_hsize  = HW'(h);
        s_vsize  = VW'(v);
        s_hstart = HW'(hs);
        s_vstart = VW'(vs);
        s_enable = en;
        s_valid  = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
        end
        chk("request accepted", got, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int  start;
        bit  seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != start) seen = 1'b1;
        end
        chk("done reached", seen, 1);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk("reset stb", m_wb_stb_o, 0);
        chk("reset we", m_wb_we_o, 0);
        chk("reset update_req", out_update_req, 0);
        chk("reset done", out_done, 0);
        chk("reset error", out_error, 0);
        chk("reset s_ready", s_ready, 1);
        @(posedge clk); #1 reset = 1'b0;

        // nominal programming, 3 busy polls then clear
        dly_lo = 0; dly_hi = 0; busy_target = 3;
        send(1279, 719, 16, 8, 1'b1);
        wait_done(200);
        chk("log length", log_q.size(), 9);
        chk("wr0 adr", log_q[0].adr, 8'h08); chk("wr0 dat", log_q[0].dat, 1279);
        chk("wr1 adr", log_q[1].adr, 8'h09); chk("wr1 dat", log_q[1].dat, 719);
        chk("wr2 adr", log_q[2].adr, 8'h0a); chk("wr2 dat", log_q[2].dat, 16);
        chk("wr3 adr", log_q[3].adr, 8'h0b); chk("wr3 dat", log_q[3].dat, 8);
        chk("wr4 adr", log_q[4].adr, 8'h04); chk("wr4 dat", log_q[4].dat, 3);
        chk("poll reads", rd_popped, 4);
        chk("update pulses", n_upd, 1);
        chk("update to done", done_cyc - upd_cyc, 8);

        // every access waits 5 cycles for ack
        dly_lo = 5; dly_hi = 5; busy_target = 0;
        send(640, 480, 2, 1, 1'b1);
        wait_done(300);
        chk("writes issued", wr_popped, 5);
        chk("write stb cycles", wr_stb_cycles, 30);

        // second request while busy is ignored
        busy_target = 1;
        send(100, 200, 3, 4, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (m_wb_stb_o && m_wb_we_o && m_wb_adr_o == 8'h09) found = 1'b1;
        end
        chk("reached vsize write", found, 1);
        #1;
        s_hsize = 14'd1; s_vsize = 14'd2; s_hstart = 14'd5; s_vstart = 14'd6; s_enable = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1 s_valid = 1'b0;
        wait_done(300);
        chk("ignored req hsize", log_q[0].dat, 100);
        chk("ignored req vsize", log_q[1].dat, 200);
        chk("ignored req ctl", log_q[4].dat, 2);

        // reset in the middle of polling
        dly_lo = 0; dly_hi = 0; busy_target = 50;
        send(10, 20, 30, 40, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (m_wb_stb_o && !m_wb_we_o) found = 1'b1;
        end
        chk("reached poll", found, 1);
        #1 reset = 1'b1;
        #1;
        chk("stb dropped in reset cycle", m_wb_stb_o, 0);
        chk("update_req in reset", out_update_req, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        busy_target = 2;
        send(11, 22, 33, 44, 1'b0);
        wait_done(200);
        chk("post-reset reads", rd_popped, 3);

        // randomized traffic
        for (int n = 0; n < 20; n++) begin
            dly_lo = 0;
            dly_hi = $urandom_range(3, 0);
            busy_target = $urandom_range(4, 0);
            send($urandom_range(16383, 0), $urandom_range(16383, 0),
                 $urandom_range(16383, 0), $urandom_range(16383, 0), 1'($urandom_range(1, 0)));
            wait_done(500);
        end

`ifdef JELLY_VSYNC_ADJUST_DE_SEQUENCER_TIMEOUT_EN
        dly_lo = 0; dly_hi = 0;
        to_mode = 1'b1; busy_forever = 1'b1;
        send(1, 2, 3, 4, 1'b1);
        wait_done(70000);
        chk("timeout bound", (done_cyc - (upd_cyc + 1)) <= 65538, 1);
        to_mode = 1'b0; busy_forever = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
